// File: rtl/qadd_pipe.sv
// qadd_pipe: two-stage multi-lane sign-magnitude adder/subtractor with saturation and valid/ready flow control.
module qadd_pipe #(
  parameter int Q = 15,
  parameter int N = 32,
  parameter int LANES = 1,
  parameter int SAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sub,
  input  logic [LANES*N-1:0] a,
  input  logic [LANES*N-1:0] b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*N-1:0] c,
  output logic [LANES-1:0]   ovf,
  output logic               ovf_sticky,
  input  logic               clr_sticky
);
  if (Q < 0 || Q > N - 1) begin : g_bad_q
    $error("Q exceeds word width");
  end
  logic                   s1_valid, s1_adv, s2_adv;
  logic [LANES*(N-1)-1:0] big_d, big_q, small_d, small_q;
  logic [LANES-1:0]       sign_d, sign_q, add_d, add_q, ovf_d;
  logic [LANES*N-1:0]     c_d;
  assign s2_adv = !out_valid || out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [N-2:0] ma, mb, bq, sq, mag;
    logic [N-1:0] sum;
    logic         sa, sb, gt, o;
    assign ma = a[i*N +: N-1];
    assign mb = b[i*N +: N-1];
    // a negative zero operand is folded to +0 before any sign decision
    assign sa = a[i*N+N-1] & |ma;
    assign sb = (b[i*N+N-1] ^ sub) & |mb;
    assign gt = ma > mb;
    assign big_d[i*(N-1) +: N-1] = gt ? ma : mb;
    assign small_d[i*(N-1) +: N-1] = gt ? mb : ma;
    assign add_d[i] = sa == sb;
    assign sign_d[i] = (sa == sb || gt) ? sa : sb;
    assign bq = big_q[i*(N-1) +: N-1];
    assign sq = small_q[i*(N-1) +: N-1];
    assign sum = {1'b0, bq} + {1'b0, sq};
    assign o = add_q[i] & sum[N-1];
    assign mag = !add_q[i] ? bq - sq : (o && SAT != 0) ? '1 : sum[N-2:0];
    assign c_d[i*N +: N] = {sign_q[i] & |mag, mag};
    assign ovf_d[i] = o;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      c <= '0;
      ovf <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s1_adv && in_valid) begin
        big_q <= big_d;
        small_q <= small_d;
        sign_q <= sign_d;
        add_q <= add_d;
      end
      if (s2_adv) out_valid <= s1_valid;
      if (s2_adv && s1_valid) begin
        c <= c_d;
        ovf <= ovf_d;
      end
      ovf_sticky <= (out_valid && out_ready && |ovf) || (ovf_sticky && !clr_sticky);
    end
  end
endmodule
